// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter driving the ALU one-hot result-mux select. A grant is
// held until the owner signals done, or until a hold watchdog reclaims it.
module onehot_rr_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16,
  parameter int CW       = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  output logic [2:0]   grant_idx,
  output logic         timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_next;
  logic [2:0]     ptr, ptr_next;
  logic [CW-1:0]  cnt, cnt_next;
  logic [N-1:0]   grant_next;
  logic [2:0]     idx_next;
  logic           timeout_next;

  logic           hold_hit;
  logic           release_now;
  logic [2:0]     arb_ptr;
  logic [N-1:0]   arb_req;
  logic [N-1:0]   masked;
  logic [2:0]     winner;
  logic           any_req;

  function automatic logic [2:0] lowest(input logic [N-1:0] v);
    lowest = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) lowest = 3'(i);
    end
  endfunction

  // State register; every output is registered here as well.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked logic so every register
    // samples the pre-edge values of the others.
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      grant     <= '0;
      grant_idx <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      cnt       <= cnt_next;
      grant     <= grant_next;
      grant_idx <= idx_next;
      timeout   <= timeout_next;
    end
  end

  // On release, search from owner+1 with the owner masked out so it cannot
  // win the back-to-back handoff.
  always_comb begin
    hold_hit    = (cnt == CW'(MAX_HOLD - 1));
    release_now = (state == BUSY) && (done || hold_hit);
    arb_ptr     = (state == BUSY) ? grant_idx + 3'd1 : ptr;
    arb_req     = (state == BUSY) ? (req & ~grant) : req;
    masked      = arb_req & ({N{1'b1}} << arb_ptr);
    winner      = (|masked) ? lowest(masked) : lowest(arb_req);
    any_req     = |arb_req;

    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = BUSY;
      BUSY:    if (release_now) state_next = any_req ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    grant_next   = grant;
    idx_next     = grant_idx;
    ptr_next     = ptr;
    cnt_next     = cnt;
    timeout_next = 1'b0;

    if (state == IDLE) begin
      if (any_req) begin
        grant_next = {{(N-1){1'b0}}, 1'b1} << winner;
        idx_next   = winner;
        cnt_next   = '0;
      end
    end else if (release_now) begin
      ptr_next     = arb_ptr;
      timeout_next = !done;
      cnt_next     = '0;
      if (any_req) begin
        grant_next = {{(N-1){1'b0}}, 1'b1} << winner;
        idx_next   = winner;
      end else begin
        grant_next = '0;
        idx_next   = '0;
      end
    end else begin
      cnt_next = cnt + CW'(1);
    end
  end

  assign grant_valid = (state == BUSY);

endmodule

// File: doc/onehot_rr_arbiter.md
# onehot_rr_arbiter

- Registered round-robin arbiter that produces the 8-bit one-hot `sel` consumed by the ALU's one-hot result mux.
- Arbitrates up to eight requesters (ALU sub-units or issue slots) and holds each grant until the owner signals `done`.
- Advances a rotating priority pointer so that no requester starves.
- Includes a hold-timeout watchdog that forcibly reclaims a grant whose owner never releases it.

## Interface
Parameters:
- `N`, default 8: number of requesters. Must equal the mux select width; only 8 is supported.
- `MAX_HOLD`, default 16: maximum number of cycles a grant may be held before forced release. Must be ≥1.
- `CW`, default 5: width of the hold counter. Must satisfy `2**CW > MAX_HOLD`.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `req`, input, N: request vector, one bit per requester, level-sensitive.
- `done`, input, 1: the current grant owner releases the grant. Ignored while no grant is held.
- `grant`, output, N: registered one-hot grant, wired directly to the mux `sel`. All zeros when idle.
- `grant_valid`, output, 1: high exactly when `grant` is non-zero. Consumers must qualify the mux output with this, because the mux defaults to `in0` when `sel` is zero.
- `grant_idx`, output, 3: binary index of the set bit of `grant`. Reads 0 when idle.
- `timeout`, output, 1: one-cycle pulse when a grant is forcibly released.

## Operation
- State machine with two states:
  - IDLE: `grant` = 0.
  - BUSY: exactly one bit of `grant` is set.
- Priority pointer `ptr` (3 bits).
  - The winner is the first set bit of `req` scanning `ptr`, `ptr+1`, … `ptr+7`, with indices taken mod 8.
  - This is a combinational search over the masked and unmasked request vectors.
- IDLE transitions:
  - If `req` ≠ 0: load `grant` = one-hot(winner) and `grant_idx` = winner, clear the hold counter, and go to BUSY.
  - Otherwise remain in IDLE.
- BUSY behaviour:
  - `req` is ignored. The grant is held even if the owner drops its request.
  - The hold counter increments each cycle.
- BUSY with `done`=1:
  - Set `ptr` = `grant_idx`+1 (mod 8; wraps 7→0).
  - Re-arbitrate in the same cycle using the updated `ptr` and the current `req`, with the current owner's bit masked out.
  - If another request is pending, load the new grant and stay in BUSY. This gives back-to-back grants with no bubble.
  - Otherwise go to IDLE.
  - The old owner may win only after one idle cycle, or when it is the sole requester on a later arbitration.
- BUSY with `done`=0 and the hold counter = `MAX_HOLD`-1:
  - Force a release and pulse `timeout` for one cycle. The pulse is coincident with the cycle in which `grant` changes.
  - Set `ptr` = owner+1 and re-arbitrate exactly as for `done`.
- Precedence: `done` and a timeout in the same cycle are treated as `done`, and `timeout` stays 0.
- Invariant: `grant` is always 0 or one-hot, never multi-hot. The bench asserts `$onehot0(grant)` every cycle.

## Timing
- Reset values: `grant`=0, `grant_valid`=0, `grant_idx`=0, `timeout`=0, `ptr`=0, hold counter=0, state=IDLE.
- Reset mid-grant: all state is cleared at that edge. Pending requests are re-arbitrated from `ptr`=0 on the first cycle after `reset` deasserts.
- Latency:
  - `req` sampled at edge k → `grant` visible after edge k, i.e. one cycle.
  - `done` at edge k → the next owner's grant is visible after edge k.
- Hold length:
  - A grant held with `done`=0 is visible for exactly `MAX_HOLD` cycles.
  - With `MAX_HOLD`=1, every grant lasts one cycle and pulses `timeout` unless `done` is high.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset state:** `reset` high for 2 cycles with `req`=8'hFF → `grant`=0 and `grant_valid`=0 during reset. The first cycle after release gives `grant`=8'h01 and `grant_idx`=0.
- **Round-robin rotation:** `req`=8'hFF held, `done` pulsed every 2nd cycle of each grant → grant sequence 01,02,04,…,80,01. This shows the wrap 7→0 and back-to-back handoff with no idle cycle.
- **Skip and wrap:** `ptr`=6 after granting 5, `req`=8'h21, `done` → next `grant`=8'h01, because scanning 6,7,0 finds bit 0 first. Then `done` → `grant`=8'h20.
- **Timeout:** `MAX_HOLD`=4, `req`=8'h0C, `done` never asserted:
  - `grant`=8'h04 for 4 cycles.
  - `timeout` pulses 1 cycle as `grant` changes to 8'h08.
  - After 4 more cycles `timeout` pulses again and `grant`=8'h04.
- **Done/timeout collision:** `done`=1 on the cycle the counter reaches `MAX_HOLD`-1 → `timeout` stays 0 and normal handoff occurs.
- **Owner drops request, then mid-grant reset:**
  - `req`=8'h10 for 1 cycle then 0 → `grant`=8'h10 held until `done`, then `grant`=0.
  - Separately, assert `reset` while `grant`=8'h40 → `grant`=0 on the next cycle and `ptr` restarts at 0.
